// File: rtl/blit_pkg.sv
`default_nettype none
// ============================================================================
// Package : blit_pkg
// Shared types and constants for the VRAM rectangle-fill engine.
// Rev     : 1.0
// ============================================================================
package blit_pkg;

  localparam int unsigned ROW_WORDS_DEF = 80;
  localparam int unsigned ROWS_DEF      = 240;

  // Register window offsets, decoded from a[4:2]
  localparam logic [2:0] REG_X      = 3'd0;
  localparam logic [2:0] REG_Y      = 3'd1;
  localparam logic [2:0] REG_W      = 3'd2;
  localparam logic [2:0] REG_H      = 3'd3;
  localparam logic [2:0] REG_PAT    = 3'd4;
  localparam logic [2:0] REG_PUSH   = 3'd5;
  localparam logic [2:0] REG_STATUS = 3'd6;
  localparam logic [2:0] REG_DONE   = 3'd7;

  typedef struct packed {
    logic [6:0]  x;
    logic [7:0]  y;
    logic [6:0]  w;
    logic [7:0]  h;
    logic [31:0] pat;
  } blit_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } blit_state_e;

endpackage
`default_nettype wire

// File: rtl/blit_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : blit_cmd_fifo
// Synchronous command queue; a push while full is dropped.
// Rev    : 1.0
// ============================================================================
module blit_cmd_fifo
  import blit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  blit_cmd_t        push_data,
  input  logic             pop,
  output blit_cmd_t        pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  blit_cmd_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/vram_blit_fill.sv
`default_nettype none
// ============================================================================
// Module : vram_blit_fill
// MMIO-programmed rectangle fill engine sharing the VRAM write port with CPU stores.
// Rev    : 1.0
// ============================================================================
module vram_blit_fill
  import blit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ROW_WORDS  = ROW_WORDS_DEF,
  parameter int unsigned ROWS       = ROWS_DEF,
  parameter int unsigned FB_AW      = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      a,
  input  logic [31:0]      d,
  input  logic             we,
  output logic [31:0]      spo,
  input  logic [FB_AW-1:0] pa,
  input  logic [31:0]      pd,
  input  logic             pwe,
  output logic [FB_AW-1:0] fb_a,
  output logic [31:0]      fb_d,
  output logic             fb_we,
  output logic             irq
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WORD_AW = FB_AW - 2;

  logic [2:0] sel;
  logic       unused_a;
  assign sel      = a[4:2];
  assign unused_a = ^{a[31:5], a[1:0]};

  // ---------------- register file + validator ----------------
  logic [6:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [6:0]  w_q, w_d;
  logic [7:0]  h_q, h_d;
  logic [31:0] pat_q, pat_d;
  logic        bad_q, bad_d;
  logic        ovf_q, ovf_d;
  logic [15:0] done_cnt_q, done_cnt_d;
  logic [31:0] spo_q, spo_d;

  logic             push_req, cmd_ok, fifo_push;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  blit_cmd_t        stage_cmd, head_cmd;
  logic             busy;

  blit_state_e state_q, state_d;

  assign stage_cmd = '{x: x_q, y: y_q, w: w_q, h: h_q, pat: pat_q};
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    w_d   = w_q;
    h_d   = h_q;
    pat_d = pat_q;
    if (we) begin
      case (sel)
        REG_X:   x_d   = d[6:0];
        REG_Y:   y_d   = d[7:0];
        REG_W:   w_d   = d[6:0];
        REG_H:   h_d   = d[7:0];
        REG_PAT: pat_d = d;
        default: ;
      endcase
    end
  end

  // Sums are widened by one bit so an out-of-range rectangle cannot wrap into range.
  always_comb begin
    push_req  = we && (sel == REG_PUSH);
    cmd_ok    = (w_q != '0) && (h_q != '0)
             && (({1'b0, x_q} + {1'b0, w_q}) <= 8'(ROW_WORDS))
             && (({1'b0, y_q} + {1'b0, h_q}) <= 9'(ROWS));
    fifo_push = push_req && cmd_ok && !fifo_full;
    bad_d     = bad_q;
    ovf_d     = ovf_q;
    if (we && (sel == REG_STATUS)) begin
      if (d[5]) ovf_d = 1'b0;
      if (d[4]) bad_d = 1'b0;
    end
    if (push_req && !cmd_ok) bad_d = 1'b1;
    if (push_req && cmd_ok && fifo_full) ovf_d = 1'b1;
  end

  always_comb begin
    case (sel)
      REG_X:      spo_d = {25'b0, x_q};
      REG_Y:      spo_d = {24'b0, y_q};
      REG_W:      spo_d = {25'b0, w_q};
      REG_H:      spo_d = {24'b0, h_q};
      REG_PAT:    spo_d = pat_q;
      REG_STATUS: spo_d = {26'b0, ovf_q, bad_q, busy, 3'(fifo_count)};
      REG_DONE:   spo_d = {16'b0, done_cnt_q};
      default:    spo_d = 32'b0;
    endcase
  end

  blit_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (stage_cmd),
    .pop       (fifo_pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------- FSM ----------------
  logic [WORD_AW-1:0] row_base_q, row_base_d;
  logic [6:0]         col_q, col_d;
  logic [7:0]         row_q, row_d;
  logic [6:0]         act_w_q, act_w_d;
  logic [7:0]         act_h_q, act_h_d;
  logic [31:0]        act_pat_q, act_pat_d;
  logic               last_col, last_row;
  logic               eng_we, irq_d, done_inc;
  logic [WORD_AW-1:0] word_addr;

  assign last_col  = (col_q == act_w_q - 7'd1);
  assign last_row  = (row_q == act_h_q - 8'd1);
  assign word_addr = row_base_q + WORD_AW'(col_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (!pwe && last_col && last_row) state_d = ST_DONE;
      ST_DONE: state_d = fifo_empty ? ST_IDLE : ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // A CPU store takes the port for its cycle; the engine simply does not advance.
  always_comb begin
    fifo_pop = (state_q == ST_LOAD);
    eng_we   = (state_q == ST_RUN) && !pwe;
    irq_d    = (state_q == ST_DONE);
    done_inc = (state_q == ST_DONE);
  end

  always_comb begin
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    act_w_d    = act_w_q;
    act_h_d    = act_h_q;
    act_pat_d  = act_pat_q;
    if (fifo_pop) begin
      row_base_d = WORD_AW'(head_cmd.y) * WORD_AW'(ROW_WORDS) + WORD_AW'(head_cmd.x);
      col_d      = '0;
      row_d      = '0;
      act_w_d    = head_cmd.w;
      act_h_d    = head_cmd.h;
      act_pat_d  = head_cmd.pat;
    end else if (eng_we) begin
      if (last_col) begin
        col_d      = '0;
        row_base_d = row_base_q + WORD_AW'(ROW_WORDS);
        row_d      = row_q + 8'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end
  end

  // ---------------- output stage ----------------
  logic [FB_AW-1:0] fb_a_q, fb_a_d;
  logic [31:0]      fb_d_q, fb_d_d;
  logic             fb_we_q, fb_we_d;
  logic             irq_q;

  always_comb begin
    fb_a_d  = '0;
    fb_d_d  = '0;
    fb_we_d = 1'b0;
    if (pwe) begin
      fb_a_d  = pa;
      fb_d_d  = pd;
      fb_we_d = 1'b1;
    end else if (eng_we) begin
      fb_a_d  = {word_addr, 2'b00};
      fb_d_d  = act_pat_q;
      fb_we_d = 1'b1;
    end
    done_cnt_d = done_inc ? done_cnt_q + 16'd1 : done_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      pat_q      <= '0;
      bad_q      <= 1'b0;
      ovf_q      <= 1'b0;
      done_cnt_q <= '0;
      spo_q      <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      act_w_q    <= '0;
      act_h_q    <= '0;
      act_pat_q  <= '0;
      fb_a_q     <= '0;
      fb_d_q     <= '0;
      fb_we_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      pat_q      <= pat_d;
      bad_q      <= bad_d;
      ovf_q      <= ovf_d;
      done_cnt_q <= done_cnt_d;
      spo_q      <= spo_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      act_w_q    <= act_w_d;
      act_h_q    <= act_h_d;
      act_pat_q  <= act_pat_d;
      fb_a_q     <= fb_a_d;
      fb_d_q     <= fb_d_d;
      fb_we_q    <= fb_we_d;
      irq_q      <= irq_d;
    end
  end

  assign spo   = spo_q;
  assign fb_a  = fb_a_q;
  assign fb_d  = fb_d_q;
  assign fb_we = fb_we_q;
  assign irq   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_blit_fill.sv
`default_nettype none
// ============================================================================
// Module : tb_vram_blit_fill
// Directed, self-checking bench for vram_blit_fill.
// Rev    : 1.0
// ============================================================================
module tb_vram_blit_fill;

  localparam logic [2:0] RX = 3'd0, RY = 3'd1, RW = 3'd2, RH = 3'd3;
  localparam logic [2:0] RPAT = 3'd4, RPUSH = 3'd5, RSTAT = 3'd6, RDONE = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0, d = '0;
  logic        we = 1'b0;
  logic [31:0] spo;
  logic [16:0] pa = '0;
  logic [31:0] pd = '0;
  logic        pwe = 1'b0;
  logic [16:0] fb_a;
  logic [31:0] fb_d;
  logic        fb_we, irq;

  vram_blit_fill dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo),
    .pa(pa), .pd(pd), .pwe(pwe),
    .fb_a(fb_a), .fb_d(fb_d), .fb_we(fb_we), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int irq_cnt = 0;
  logic [16:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_we) begin
      wa_q.push_back(fb_a);
      wd_q.push_back(fb_d);
      wc_q.push_back(cyc);
    end
    if (irq) irq_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] val);
    @(negedge clk);
    a = {27'b0, idx, 2'b00}; d = val; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, output logic [31:0] val);
    @(negedge clk);
    a = {27'b0, idx, 2'b00}; we = 1'b0;
    @(posedge clk);
    #1 val = spo;
  endtask

  task automatic set_rect(input int x, input int y, input int w, input int h, input logic [31:0] p);
    wr(RX, 32'(x)); wr(RY, 32'(y)); wr(RW, 32'(w)); wr(RH, 32'(h)); wr(RPAT, p);
  endtask

  task automatic clr_log();
    @(posedge clk);
    #1;
    wa_q.delete(); wd_q.delete(); wc_q.delete(); irq_cnt = 0;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int i = 0; i < budget; i++) begin
      rd(RSTAT, s);
      if (s[3] == 1'b0) break;
    end
    chk("idle_wait", {31'b0, s[3]}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_we(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fb_we) break;
    end
    chk("we_seen", {31'b0, fb_we}, 32'd1);
  endtask

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] r;

  initial begin
    vecs[0] = '{RX,   32'hFFFF_FFFF, 32'h0000_007F, "rb_x_mask"};
    vecs[1] = '{RY,   32'hFFFF_FFFF, 32'h0000_00FF, "rb_y_mask"};
    vecs[2] = '{RW,   32'hFFFF_FF80, 32'h0000_0000, "rb_w_mask"};
    vecs[3] = '{RH,   32'h0000_01A5, 32'h0000_00A5, "rb_h_mask"};
    vecs[4] = '{RPAT, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rb_pat"};
    vecs[5] = '{RX,   32'h0000_0005, 32'h0000_0005, "rb_x_val"};

    repeat (3) @(negedge clk);
    chk("rst_fb_we", {31'b0, fb_we}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_spo", spo, 32'd0);
    rst = 1'b1;
    rd(RSTAT, r); chk("rst_status", r, 32'h0);
    rd(RDONE, r); chk("rst_done_cnt", r, 32'h0);

    foreach (vecs[i]) begin
      wr(vecs[i].idx, vecs[i].wdata);
      rd(vecs[i].idx, r);
      chk(vecs[i].name, r, vecs[i].exp);
    end

    // Basic 2x2 fill
    set_rect(2, 3, 2, 2, 32'hE0E0_E0E0);
    clr_log();
    wr(RPUSH, 32'h0);
    wait_idle(200);
    chk("f1_count", 32'(wa_q.size()), 32'd4);
    if (wa_q.size() == 4) begin
      chk("f1_a0", 32'(wa_q[0]), 32'h3C8);
      chk("f1_a1", 32'(wa_q[1]), 32'h3CC);
      chk("f1_a2", 32'(wa_q[2]), 32'h508);
      chk("f1_a3", 32'(wa_q[3]), 32'h50C);
      chk("f1_d0", wd_q[0], 32'hE0E0_E0E0);
      chk("f1_consec", 32'(wc_q[3] - wc_q[0]), 32'd3);
    end
    chk("f1_irq", 32'(irq_cnt), 32'd1);
    rd(RDONE, r); chk("f1_done_cnt", r, 32'd1);

    // Same fill with a CPU store landing on the second engine cycle
    clr_log();
    wr(RPUSH, 32'h0);
    wait_we(50);
    pa = 17'h10; pd = 32'h1234_5678; pwe = 1'b1;
    @(negedge clk);
    pwe = 1'b0;
    wait_idle(200);
    chk("f2_count", 32'(wa_q.size()), 32'd5);
    if (wa_q.size() == 5) begin
      chk("f2_a0", 32'(wa_q[0]), 32'h3C8);
      chk("f2_a1", 32'(wa_q[1]), 32'h10);
      chk("f2_d1", wd_q[1], 32'h1234_5678);
      chk("f2_a2", 32'(wa_q[2]), 32'h3CC);
      chk("f2_a3", 32'(wa_q[3]), 32'h508);
      chk("f2_a4", 32'(wa_q[4]), 32'h50C);
      chk("f2_d4", wd_q[4], 32'hE0E0_E0E0);
    end
    chk("f2_irq", 32'(irq_cnt), 32'd1);
    rd(RDONE, r); chk("f2_done_cnt", r, 32'd2);

    // Rejected rectangles
    clr_log();
    set_rect(79, 0, 2, 1, 32'h1);
    wr(RPUSH, 32'h0);
    rd(RSTAT, r); chk("bad_xw", r, 32'h10);
    wr(RSTAT, 32'h10);
    rd(RSTAT, r); chk("bad_clr1", r, 32'h0);
    set_rect(0, 0, 1, 0, 32'h1);
    wr(RPUSH, 32'h0);
    rd(RSTAT, r); chk("bad_h0", r, 32'h10);
    set_rect(0, 239, 1, 2, 32'h1);
    wr(RPUSH, 32'h0);
    rd(RSTAT, r); chk("bad_yh", r, 32'h10);
    repeat (10) @(negedge clk);
    chk("bad_no_we", 32'(wa_q.size()), 32'd0);
    wr(RSTAT, 32'h10);
    rd(RSTAT, r); chk("bad_clr", r, 32'h0);

    // Overflow: long command running, then six 1x1 pushes back-to-back
    clr_log();
    set_rect(0, 0, 80, 2, 32'hA5A5_A5A5);
    wr(RPUSH, 32'h0);
    set_rect(5, 5, 1, 1, 32'h5A5A_5A5A);
    @(negedge clk);
    a = {27'b0, RPUSH, 2'b00}; we = 1'b1;
    repeat (6) @(negedge clk);
    we = 1'b0;
    rd(RSTAT, r); chk("ovf_status", r, 32'h2C);
    wait_idle(2000);
    chk("ovf_irq", 32'(irq_cnt), 32'd5);
    chk("ovf_writes", 32'(wa_q.size()), 32'd164);
    rd(RDONE, r); chk("ovf_done_cnt", r, 32'd7);
    wr(RSTAT, 32'h20);
    rd(RSTAT, r); chk("ovf_clr", r, 32'h0);

    // Full screen
    clr_log();
    set_rect(0, 0, 80, 240, 32'h1C1C_1C1C);
    wr(RPUSH, 32'h0);
    wait_idle(25000);
    chk("fs_count", 32'(wa_q.size()), 32'd19200);
    if (wa_q.size() == 19200) begin
      chk("fs_first", 32'(wa_q[0]), 32'h0);
      chk("fs_mid", 32'(wa_q[9600]), 32'h9600);
      chk("fs_last", 32'(wa_q[19199]), 32'h12BFC);
    end
    chk("fs_irq", 32'(irq_cnt), 32'd1);
    rd(RSTAT, r); chk("fs_status", r, 32'h0);
    rd(RDONE, r); chk("fs_done_cnt", r, 32'd8);

    // Reset in the middle of a run
    set_rect(0, 0, 80, 10, 32'h3);
    wr(RPUSH, 32'h0);
    wr(RPUSH, 32'h0);
    wait_we(50);
    #2 rst = 1'b0;
    #1 chk("mrst_fb_we", {31'b0, fb_we}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clr_log();
    repeat (30) @(negedge clk);
    chk("mrst_no_we", 32'(wa_q.size()), 32'd0);
    rd(RSTAT, r); chk("mrst_status", r, 32'h0);
    rd(RDONE, r); chk("mrst_done_cnt", r, 32'h0);
    rd(RW, r);    chk("mrst_stage_w", r, 32'h0);
    set_rect(3, 1, 1, 1, 32'h77);
    wr(RPUSH, 32'h0);
    wait_idle(200);
    chk("mrst_new_count", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) chk("mrst_new_a", 32'(wa_q[0]), 32'h14C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
